pipe_regs_ctrl: RTL and testbench
=================================

# pipe_regs_ctrl

Pipeline register bank and hazard controller for the 5-stage RV32 core. It captures the next-state IF/ID, ID/EX, EX/MEM and MEM/WB structs produced by each stage and presents them registered to the following stage. It detects load-use hazards and inserts one bubble, and flushes younger stages on a taken branch resolved in MEM. It also keeps saturating stall and flush event counters for performance debug.

## Interface

Parameters:
- CNT_W, 16: width of the stall and flush counters.
- NOP_INSTR, 32'h0000_0013: instruction word loaded into IF/ID on reset and on flush (`addi x0,x0,0`).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_id_d  in  if_id_data_t  fetch output (pc_address, instruc).
- id_ex_ctrl_d  in  id_ex_control_t  decode control.
- id_ex_data_d  in  id_ex_data_t  decode data.
- ex_mem_ctrl_d  in  ex_mem_control_t  execute control (includes ALU_zero).
- ex_mem_data_d  in  ex_mem_data_t  execute data.
- mem_wb_ctrl_d  in  mem_wb_control_t  memory-stage control.
- mem_wb_data_d  in  mem_wb_data_t  memory-stage data.
- if_id_q, id_ex_ctrl_q, id_ex_data_q, ex_mem_ctrl_q, ex_mem_data_q, mem_wb_ctrl_q, mem_wb_data_q  out  matching struct  registered stage contents.
- pc_write  out  1  PC update enable for fetch (comb).
- branch_taken  out  1  redirect fetch (comb).
- branch_target  out  32  equals ex_mem_data_q.branch_adder_sum.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.

## Operation

- rs1/rs2 of the instruction in ID: if_id_q.instruc[19:15] / [24:20].
- load_use = id_ex_ctrl_q.M_mem_read & (id_ex_data_q.rd != 0) & (rd == rs1 | rd == rs2). Compare both fields regardless of format; false stalls on U/J-type are accepted.
- branch_taken = ex_mem_ctrl_q.M_branch & ex_mem_ctrl_q.ALU_zero.
- stall = load_use & ~branch_taken. Flush has priority.
- pc_write = ~stall.
- Clock edge, normal operation: every *_q loads its *_d.
- Clock edge, stall:
  - if_id_q holds.
  - id_ex_ctrl_q is cleared to 0 (bubble).
  - id_ex_data_q loads id_ex_data_d. It is don't-care under a bubble.
  - EX/MEM and MEM/WB advance.
- Clock edge, branch_taken:
  - if_id_q becomes {pc 0, NOP_INSTR}.
  - id_ex_ctrl_q and ex_mem_ctrl_q are cleared to 0.
  - Data halves load their *_d.
  - mem_wb_* advance, so the branch itself retires.
- Counters:
  - stall_cnt increments on each stall edge.
  - flush_cnt increments on each branch_taken edge.
  - Both saturate at all-ones and never wrap.

## Timing

- Reset (asynchronous assert, synchronous-edge release):
  - All *_q are zero, except if_id_q.instruc = NOP_INSTR.
  - Counters are 0.
  - pc_write = 1 and branch_taken = 0, because they follow from the zero state.
- Latency is 1 cycle per stage register.
- Load-use costs exactly 1 bubble: the dependent instruction stays in ID for 2 cycles, and load_use is false on the second.
- A taken branch discards the 3 younger instructions (IF/ID, ID/EX, EX/MEM). Fetch redirects on the same edge (pc_write = 1).
- Stall and branch in the same cycle: flush only. stall_cnt does not increment.
- Back-to-back loads to the same rd each cause an independent single bubble.
- rst_n assertion mid-stall or mid-flush clears everything immediately. No pending hazard survives reset.

## Structure

- cpu_pkg gains:
  - localparam NOP_INSTR default value.
  - Helper functions get_rs1/get_rs2 (instruction → 5-bit field).
  - Reset-value constants for if_id_data_t and the zero control structs.
- Sub-module hazard_detect_unit (combinational):
  - Inputs: if_id_q, id_ex_ctrl_q, id_ex_data_q, ex_mem_ctrl_q.
  - Outputs: stall, branch_taken, pc_write.
- Top-level pipe_regs_ctrl holds the registers and counters.

## Test plan

- Reset, then rst_n=1 with idle inputs → if_id_q.instruc=0x00000013, all control outputs 0, counters 0, pc_write=1.
- `lw x5,0(x1)` in EX (M_mem_read=1, rd=5) with `add x6,x5,x2` in ID → one edge with pc_write=0, if_id_q held, id_ex_ctrl_q=0. Next edge advances normally. stall_cnt=1.
- Load with rd=0 followed by an instruction using x0 → no stall, stall_cnt=0.
- ex_mem_ctrl_q M_branch=1, ALU_zero=1, branch_adder_sum=0x40 → branch_target=0x40, branch_taken=1. Next edge: if_id NOP, id_ex/ex_mem control 0, flush_cnt=1.
- Load-use and taken branch in the same cycle → flush behaviour only. stall_cnt unchanged, flush_cnt +1.
- CNT_W=4: drive 20 stall events → stall_cnt saturates at 0xF. Then assert rst_n=0 mid-stall → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline struct types, field helpers and reset constants for the RV32 core
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc_address;
        logic [31:0] instruc;
    } if_id_data_t;

    typedef struct packed {
        logic [1:0] EX_alu_op;
        logic       EX_alu_src;
        logic       M_mem_read;
        logic       M_mem_write;
        logic       M_branch;
        logic       WB_reg_write;
        logic       WB_mem_to_reg;
    } id_ex_control_t;

    typedef struct packed {
        logic [31:0] pc_address;
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] imm;
        logic [4:0]  rd;
    } id_ex_data_t;

    typedef struct packed {
        logic M_mem_read;
        logic M_mem_write;
        logic M_branch;
        logic ALU_zero;
        logic WB_reg_write;
        logic WB_mem_to_reg;
    } ex_mem_control_t;

    typedef struct packed {
        logic [31:0] branch_adder_sum;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  rd;
    } ex_mem_data_t;

    typedef struct packed {
        logic WB_reg_write;
        logic WB_mem_to_reg;
    } mem_wb_control_t;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
    } mem_wb_data_t;

    localparam if_id_data_t     IF_ID_RESET       = '{pc_address: 32'd0, instruc: NOP_INSTR_DEFAULT};
    localparam id_ex_control_t  ID_EX_CTRL_ZERO   = '0;
    localparam ex_mem_control_t EX_MEM_CTRL_ZERO  = '0;
    localparam mem_wb_control_t MEM_WB_CTRL_ZERO  = '0;

    function automatic logic [4:0] get_rs1(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [31:0] instr);
        return instr[24:20];
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - combinational load-use and taken-branch detection
module hazard_detect_unit
    import cpu_pkg::*;
(
    input  if_id_data_t     i_if_id_q,
    input  id_ex_control_t  i_id_ex_ctrl_q,
    input  id_ex_data_t     i_id_ex_data_q,
    input  ex_mem_control_t i_ex_mem_ctrl_q,
    output logic            o_stall,
    output logic            o_branch_taken,
    output logic            o_pc_write
);

    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_load_use;

    // Both source fields are compared for every format; spurious stalls on U/J-type are harmless.
    assign w_rs1 = get_rs1(i_if_id_q.instruc);
    assign w_rs2 = get_rs2(i_if_id_q.instruc);

    assign w_load_use = i_id_ex_ctrl_q.M_mem_read
                      & (i_id_ex_data_q.rd != 5'd0)
                      & ((i_id_ex_data_q.rd == w_rs1) | (i_id_ex_data_q.rd == w_rs2));

    assign o_branch_taken = i_ex_mem_ctrl_q.M_branch & i_ex_mem_ctrl_q.ALU_zero;
    assign o_stall        = w_load_use & ~o_branch_taken;
    assign o_pc_write     = ~o_stall;

endmodule

// File: rtl/pipe_regs_ctrl.sv
// rtl/pipe_regs_ctrl.sv - IF/ID..MEM/WB pipeline registers with stall/flush control and event counters
module pipe_regs_ctrl
    import cpu_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  if_id_data_t     if_id_d,
    input  id_ex_control_t  id_ex_ctrl_d,
    input  id_ex_data_t     id_ex_data_d,
    input  ex_mem_control_t ex_mem_ctrl_d,
    input  ex_mem_data_t    ex_mem_data_d,
    input  mem_wb_control_t mem_wb_ctrl_d,
    input  mem_wb_data_t    mem_wb_data_d,
    output if_id_data_t     if_id_q,
    output id_ex_control_t  id_ex_ctrl_q,
    output id_ex_data_t     id_ex_data_q,
    output ex_mem_control_t ex_mem_ctrl_q,
    output ex_mem_data_t    ex_mem_data_q,
    output mem_wb_control_t mem_wb_ctrl_q,
    output mem_wb_data_t    mem_wb_data_q,
    output logic            pc_write,
    output logic            branch_taken,
    output logic [31:0]     branch_target,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    if_id_data_t      r_if_id;
    id_ex_control_t   r_id_ex_ctrl;
    id_ex_data_t      r_id_ex_data;
    ex_mem_control_t  r_ex_mem_ctrl;
    ex_mem_data_t     r_ex_mem_data;
    mem_wb_control_t  r_mem_wb_ctrl;
    mem_wb_data_t     r_mem_wb_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_stall;
    logic w_branch_taken;
    logic w_pc_write;

    hazard_detect_unit u_hazard (
        .i_if_id_q       (r_if_id),
        .i_id_ex_ctrl_q  (r_id_ex_ctrl),
        .i_id_ex_data_q  (r_id_ex_data),
        .i_ex_mem_ctrl_q (r_ex_mem_ctrl),
        .o_stall         (w_stall),
        .o_branch_taken  (w_branch_taken),
        .o_pc_write      (w_pc_write)
    );

    // Flush outranks stall: the hazard unit already masks stall when a branch is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id       <= '{pc_address: 32'd0, instruc: NOP_INSTR};
            r_id_ex_ctrl  <= ID_EX_CTRL_ZERO;
            r_id_ex_data  <= '0;
            r_ex_mem_ctrl <= EX_MEM_CTRL_ZERO;
            r_ex_mem_data <= '0;
            r_mem_wb_ctrl <= MEM_WB_CTRL_ZERO;
            r_mem_wb_data <= '0;
        end else begin
            r_id_ex_data  <= id_ex_data_d;
            r_ex_mem_data <= ex_mem_data_d;
            r_mem_wb_ctrl <= mem_wb_ctrl_d;
            r_mem_wb_data <= mem_wb_data_d;
            if (w_branch_taken) begin
                r_if_id       <= '{pc_address: 32'd0, instruc: NOP_INSTR};
                r_id_ex_ctrl  <= ID_EX_CTRL_ZERO;
                r_ex_mem_ctrl <= EX_MEM_CTRL_ZERO;
            end else if (w_stall) begin
                r_id_ex_ctrl  <= ID_EX_CTRL_ZERO;
                r_ex_mem_ctrl <= ex_mem_ctrl_d;
            end else begin
                r_if_id       <= if_id_d;
                r_id_ex_ctrl  <= id_ex_ctrl_d;
                r_ex_mem_ctrl <= ex_mem_ctrl_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign if_id_q       = r_if_id;
    assign id_ex_ctrl_q  = r_id_ex_ctrl;
    assign id_ex_data_q  = r_id_ex_data;
    assign ex_mem_ctrl_q = r_ex_mem_ctrl;
    assign ex_mem_data_q = r_ex_mem_data;
    assign mem_wb_ctrl_q = r_mem_wb_ctrl;
    assign mem_wb_data_q = r_mem_wb_data;
    assign pc_write      = w_pc_write;
    assign branch_taken  = w_branch_taken;
    assign branch_target = r_ex_mem_data.branch_adder_sum;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_pipe_regs_ctrl.sv
// tb/tb_pipe_regs_ctrl.sv - directed and randomized bench for pipe_regs_ctrl against a behavioural model
module tb_pipe_regs_ctrl;
    import cpu_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic            clk;
    logic            rst_n;
    if_id_data_t     if_id_d;
    id_ex_control_t  id_ex_ctrl_d;
    id_ex_data_t     id_ex_data_d;
    ex_mem_control_t ex_mem_ctrl_d;
    ex_mem_data_t    ex_mem_data_d;
    mem_wb_control_t mem_wb_ctrl_d;
    mem_wb_data_t    mem_wb_data_d;
    if_id_data_t     if_id_q;
    id_ex_control_t  id_ex_ctrl_q;
    id_ex_data_t     id_ex_data_q;
    ex_mem_control_t ex_mem_ctrl_q;
    ex_mem_data_t    ex_mem_data_q;
    mem_wb_control_t mem_wb_ctrl_q;
    mem_wb_data_t    mem_wb_data_q;
    logic            pc_write;
    logic            branch_taken;
    logic [31:0]     branch_target;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_regs_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_id_d       (if_id_d),
        .id_ex_ctrl_d  (id_ex_ctrl_d),
        .id_ex_data_d  (id_ex_data_d),
        .ex_mem_ctrl_d (ex_mem_ctrl_d),
        .ex_mem_data_d (ex_mem_data_d),
        .mem_wb_ctrl_d (mem_wb_ctrl_d),
        .mem_wb_data_d (mem_wb_data_d),
        .if_id_q       (if_id_q),
        .id_ex_ctrl_q  (id_ex_ctrl_q),
        .id_ex_data_q  (id_ex_data_q),
        .ex_mem_ctrl_q (ex_mem_ctrl_q),
        .ex_mem_data_q (ex_mem_data_q),
        .mem_wb_ctrl_q (mem_wb_ctrl_q),
        .mem_wb_data_q (mem_wb_data_q),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: what the pipeline registers should hold right now.
    if_id_data_t     m_if_id;
    id_ex_control_t  m_id_ex_ctrl;
    id_ex_data_t     m_id_ex_data;
    ex_mem_control_t m_ex_mem_ctrl;
    ex_mem_data_t    m_ex_mem_data;
    mem_wb_control_t m_mem_wb_ctrl;
    mem_wb_data_t    m_mem_wb_data;
    int              m_stall_cnt;
    int              m_flush_cnt;

    localparam logic [31:0] ADD_X6_X5_X2 = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] ADD_X7_X0_X0 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd7, 7'h33};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_branch();
        return m_ex_mem_ctrl.M_branch && m_ex_mem_ctrl.ALU_zero;
    endfunction

    function automatic bit m_stall();
        logic [4:0] rd;
        bit uses;
        rd   = m_id_ex_data.rd;
        uses = (rd == m_if_id.instruc[19:15]) || (rd == m_if_id.instruc[24:20]);
        return m_id_ex_ctrl.M_mem_read && (rd != 0) && uses && !m_branch();
    endfunction

    task automatic m_reset();
        m_if_id       = '{pc_address: 32'd0, instruc: 32'h0000_0013};
        m_id_ex_ctrl  = '0;
        m_id_ex_data  = '0;
        m_ex_mem_ctrl = '0;
        m_ex_mem_data = '0;
        m_mem_wb_ctrl = '0;
        m_mem_wb_data = '0;
        m_stall_cnt   = 0;
        m_flush_cnt   = 0;
    endtask

    task automatic compare_all();
        check("if_id_q",       if_id_q,       m_if_id);
        check("id_ex_ctrl_q",  id_ex_ctrl_q,  m_id_ex_ctrl);
        check("id_ex_data_q",  id_ex_data_q,  m_id_ex_data);
        check("ex_mem_ctrl_q", ex_mem_ctrl_q, m_ex_mem_ctrl);
        check("ex_mem_data_q", ex_mem_data_q, m_ex_mem_data);
        check("mem_wb_ctrl_q", mem_wb_ctrl_q, m_mem_wb_ctrl);
        check("mem_wb_data_q", mem_wb_data_q, m_mem_wb_data);
        check("branch_taken",  branch_taken,  m_branch());
        check("pc_write",      pc_write,      !m_stall());
        check("branch_target", branch_target, m_ex_mem_data.branch_adder_sum);
        check("stall_cnt",     stall_cnt,     m_stall_cnt);
        check("flush_cnt",     flush_cnt,     m_flush_cnt);
    endtask

    // One clock edge: predict the post-edge contents, clock, then compare everything.
    task automatic cycle();
        bit br;
        bit st;
        br = m_branch();
        st = m_stall();
        if (!br && !st) m_if_id = if_id_d;
        else if (br)    m_if_id = '{pc_address: 32'd0, instruc: 32'h0000_0013};
        m_id_ex_ctrl  = (br || st) ? id_ex_control_t'(0) : id_ex_ctrl_d;
        m_ex_mem_ctrl = br ? ex_mem_control_t'(0) : ex_mem_ctrl_d;
        m_id_ex_data  = id_ex_data_d;
        m_ex_mem_data = ex_mem_data_d;
        m_mem_wb_ctrl = mem_wb_ctrl_d;
        m_mem_wb_data = mem_wb_data_d;
        if (st && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (br && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive_idle();
        if_id_d       = '0;
        id_ex_ctrl_d  = '0;
        id_ex_data_d  = '0;
        ex_mem_ctrl_d = '0;
        ex_mem_data_d = '0;
        mem_wb_ctrl_d = '0;
        mem_wb_data_d = '0;
    endtask

    task automatic drive_random();
        logic [31:0] instr;
        instr        = $urandom;
        instr[19:15] = 5'($urandom_range(0, 3));
        instr[24:20] = 5'($urandom_range(0, 3));
        if_id_d      = '{pc_address: $urandom, instruc: instr};
        id_ex_ctrl_d = id_ex_control_t'(8'($urandom));
        id_ex_data_d = '{pc_address: $urandom, read_data1: $urandom, read_data2: $urandom,
                         imm: $urandom, rd: 5'($urandom_range(0, 3))};
        ex_mem_ctrl_d = ex_mem_control_t'(6'($urandom));
        ex_mem_data_d = '{branch_adder_sum: $urandom, alu_result: $urandom,
                          write_data: $urandom, rd: 5'($urandom)};
        mem_wb_ctrl_d = mem_wb_control_t'(2'($urandom));
        mem_wb_data_d = '{read_data: $urandom, alu_result: $urandom, rd: 5'($urandom)};
    endtask

    task automatic drive_load_use_pair();
        drive_idle();
        id_ex_ctrl_d.M_mem_read = 1'b1;
        id_ex_data_d.rd         = 5'd5;
        if_id_d                 = '{pc_address: 32'h0000_0104, instruc: ADD_X6_X5_X2};
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_nop", if_id_q.instruc, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("idle_pc_write", pc_write, 1'b1);

        // Load-use: one bubble, ID holds for exactly one extra edge.
        drive_load_use_pair();
        cycle();
        check("lu_pc_write_low", pc_write, 1'b0);
        if_id_d = '{pc_address: 32'h0000_0108, instruc: ADD_X7_X0_X0};
        id_ex_ctrl_d = '0;
        cycle();
        check("lu_if_id_held", if_id_q.instruc, ADD_X6_X5_X2);
        check("lu_bubble", id_ex_ctrl_q, 8'h00);
        check("lu_stall_cnt", stall_cnt, 4'd1);
        check("lu_released", pc_write, 1'b1);
        cycle();
        check("lu_advance", if_id_q.instruc, ADD_X7_X0_X0);

        // Load to x0 never stalls.
        drive_idle();
        id_ex_ctrl_d.M_mem_read = 1'b1;
        if_id_d.instruc         = ADD_X7_X0_X0;
        cycle();
        check("x0_no_stall", pc_write, 1'b1);
        drive_idle();
        cycle();
        check("x0_stall_cnt", stall_cnt, 4'd1);

        // Taken branch alone.
        drive_idle();
        ex_mem_ctrl_d.M_branch = 1'b1;
        ex_mem_ctrl_d.ALU_zero = 1'b1;
        ex_mem_data_d.branch_adder_sum = 32'h40;
        id_ex_ctrl_d = 8'hFF;
        if_id_d      = '{pc_address: 32'h200, instruc: 32'h1234_5678};
        cycle();
        check("br_taken", branch_taken, 1'b1);
        check("br_target", branch_target, 32'h40);
        ex_mem_ctrl_d = 6'h3F;
        cycle();
        check("br_if_id_nop", if_id_q, {32'd0, 32'h0000_0013});
        check("br_ex_mem_ctrl", ex_mem_ctrl_q, 6'h00);
        check("br_flush_cnt", flush_cnt, 4'd1);

        // Load-use and taken branch together: flush only.
        drive_load_use_pair();
        ex_mem_ctrl_d.M_branch = 1'b1;
        ex_mem_ctrl_d.ALU_zero = 1'b1;
        ex_mem_data_d.branch_adder_sum = 32'h80;
        cycle();
        check("both_pc_write", pc_write, 1'b1);
        drive_idle();
        cycle();
        check("both_stall_cnt", stall_cnt, 4'd1);
        check("both_flush_cnt", flush_cnt, 4'd2);
        check("both_if_id_nop", if_id_q.instruc, 32'h0000_0013);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            cycle();
        end

        // Saturate stall_cnt: a stall-capable pair every edge yields a bubble every other edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_load_use_pair();
            cycle();
        end
        check("sat_stall_cnt", stall_cnt, 4'hF);

        // Enter a stall, then reset asynchronously between edges.
        if (!m_stall()) begin
            drive_load_use_pair();
            cycle();
        end
        check("mid_stall_pc_write", pc_write, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        compare_all();
        check("async_rst_pc_write", pc_write, 1'b1);
        check("async_rst_stall_cnt", stall_cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
